// File: rtl/armleocpu_defines.sv
// Shared constants and the writeback request type for the ArmleoCPU writeback path.
package armleocpu_defines;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/armleocpu_wb_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on reserve, cleared when the load writes back.
module armleocpu_wb_scoreboard
    import armleocpu_defines::*;
(
    input  logic                  clk,
    input  logic                  async_rst_n,
    input  logic                  set_valid,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_valid,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    output logic [NUM_REGS-1:0]   pending
);

    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] pending_q;

    // Clear is applied before set so a reserve racing a load-clear of the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (clr_valid)
            pending_d[clr_addr] = 1'b0;
        if (set_valid && (set_addr != '0))
            pending_d[set_addr] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n)
            pending_q <= '0;
        else
            pending_q <= pending_d;
    end

    assign pending = pending_q;

endmodule

// File: rtl/armleocpu_regfile_writeback.sv
// Regfile writeback arbiter: loads always win, execute waits on pending loads to its destination.
// Define ARMLEOCPU_WB_BYPASS_EN for 0-cycle (combinational) writeback; default is registered.
module armleocpu_regfile_writeback
    import armleocpu_defines::*;
(
    input  logic                  clk,
    input  logic                  async_rst_n,

    input  logic                  l_valid,
    output logic                  l_ready,
    input  logic [REG_ADDR_W-1:0] l_addr,
    input  logic [XLEN-1:0]       l_data,

    input  logic                  e_valid,
    output logic                  e_ready,
    input  logic [REG_ADDR_W-1:0] e_addr,
    input  logic [XLEN-1:0]       e_data,

    input  logic                  reserve_valid,
    input  logic [REG_ADDR_W-1:0] reserve_addr,

    output logic                  rd_write,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       rd_data,
    output logic [NUM_REGS-1:0]   pending
);

    logic    l_accept;
    logic    e_accept;
    logic    wr_now;
    wb_req_t req;
    wb_req_t last_d;
    wb_req_t last_q;

    assign l_ready = 1'b1;
    assign e_ready = !l_valid && !pending[e_addr]
                   && !(reserve_valid && (reserve_addr == e_addr) && (e_addr != '0));

    // Nothing is accepted while reset is held, which also keeps the bypass outputs quiet.
    always_comb begin
        l_accept = l_valid && async_rst_n;
        e_accept = e_valid && e_ready && async_rst_n;
        req      = l_accept ? '{addr: l_addr, data: l_data}
                            : '{addr: e_addr, data: e_data};
        wr_now   = (l_accept || e_accept) && (req.addr != '0);
        last_d   = wr_now ? req : last_q;
    end

    // NOTE: async reset clears the held write so an in-flight write is dropped immediately.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n)
            last_q <= '0;
        else
            last_q <= last_d;
    end

    armleocpu_wb_scoreboard u_scoreboard (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .set_valid   (reserve_valid),
        .set_addr    (reserve_addr),
        .clr_valid   (l_accept),
        .clr_addr    (l_addr),
        .pending     (pending)
    );

`ifdef ARMLEOCPU_WB_BYPASS_EN
    assign rd_write = wr_now;
    assign rd_addr  = wr_now ? req.addr : last_q.addr;
    assign rd_data  = wr_now ? req.data : last_q.data;
`else
    logic rd_write_d;
    logic rd_write_q;

    always_comb begin
        rd_write_d = wr_now;
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n)
            rd_write_q <= 1'b0;
        else
            rd_write_q <= rd_write_d;
    end

    assign rd_write = rd_write_q;
    assign rd_addr  = last_q.addr;
    assign rd_data  = last_q.data;
`endif

endmodule

// File: tb/tb_armleocpu_regfile_writeback.sv
// Self-checking bench for armleocpu_regfile_writeback: directed scenarios then random traffic vs a reference model.
module tb_armleocpu_regfile_writeback;
    import armleocpu_defines::*;

    logic                  clk = 1'b0;
    logic                  async_rst_n;
    logic                  l_valid, e_valid, reserve_valid;
    logic                  l_ready, e_ready, rd_write;
    logic [REG_ADDR_W-1:0] l_addr, e_addr, reserve_addr, rd_addr;
    logic [XLEN-1:0]       l_data, e_data, rd_data;
    logic [NUM_REGS-1:0]   pending;

    armleocpu_regfile_writeback dut (
        .clk           (clk),
        .async_rst_n   (async_rst_n),
        .l_valid       (l_valid),
        .l_ready       (l_ready),
        .l_addr        (l_addr),
        .l_data        (l_data),
        .e_valid       (e_valid),
        .e_ready       (e_ready),
        .e_addr        (e_addr),
        .e_data        (e_data),
        .reserve_valid (reserve_valid),
        .reserve_addr  (reserve_addr),
        .rd_write      (rd_write),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: set of outstanding loads and the last register write seen.
    bit        pm [NUM_REGS];
    bit [4:0]  m_addr;
    bit [31:0] m_data;

    // Values observed at the cycle where the write of the last step should be visible.
    logic        obs_wr, obs_eready;
    logic [4:0]  obs_addr;
    logic [31:0] obs_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i] = pm[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) pm[i] = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic idle_inputs();
        l_valid = 0; l_addr = '0; l_data = '0;
        e_valid = 0; e_addr = '0; e_data = '0;
        reserve_valid = 0; reserve_addr = '0;
    endtask

    // Called shortly after a rising edge; drives one cycle of requests and checks it.
    task automatic step(input bit lv, input bit [4:0] la, input bit [31:0] ld,
                        input bit ev, input bit [4:0] ea, input bit [31:0] ed,
                        input bit rv, input bit [4:0] ra);
        bit exp_er, acc, wr;
        bit [4:0]  a;
        bit [31:0] d;
        l_valid = lv; l_addr = la; l_data = ld;
        e_valid = ev; e_addr = ea; e_data = ed;
        reserve_valid = rv; reserve_addr = ra;
        @(negedge clk);
        exp_er = !lv && !pm[ea] && !(rv && ra == ea && ea != 0);
        check("l_ready", {31'b0, l_ready}, 32'd1);
        check("e_ready", {31'b0, e_ready}, {31'b0, exp_er});
        obs_eready = e_ready;
        acc = lv || (ev && exp_er);
        a   = lv ? la : ea;
        d   = lv ? ld : ed;
        wr  = acc && (a != 0);
        if (wr) begin
            m_addr = a;
            m_data = d;
        end
`ifdef ARMLEOCPU_WB_BYPASS_EN
        obs_wr = rd_write; obs_addr = rd_addr; obs_data = rd_data;
`endif
        @(posedge clk);
        #1;
        if (lv) pm[la] = 1'b0;
        if (rv && ra != 0) pm[ra] = 1'b1;
`ifndef ARMLEOCPU_WB_BYPASS_EN
        obs_wr = rd_write; obs_addr = rd_addr; obs_data = rd_data;
`endif
        check("rd_write", {31'b0, obs_wr}, {31'b0, wr});
        check("rd_addr", {27'b0, obs_addr}, {27'b0, m_addr});
        check("rd_data", obs_data, m_data);
        check("pending", pending, model_pending());
    endtask

    initial begin
        idle_inputs();
        model_reset();
        async_rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_write", {31'b0, rd_write}, 32'd0);
        check("rst_pending", pending, 32'd0);
        check("rst_l_ready", {31'b0, l_ready}, 32'd1);
        @(negedge clk);
        async_rst_n = 1;
        @(posedge clk);
        #1;

        // Plain execute write.
        step(0, 0, 0, 1, 5'd1, 32'hFF00FF00, 0, 0);
        check("s1_e_ready", {31'b0, obs_eready}, 32'd1);
        check("s1_wr", {31'b0, obs_wr}, 32'd1);
        check("s1_addr", {27'b0, obs_addr}, 32'd1);
        check("s1_data", obs_data, 32'hFF00FF00);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("s1_wr_drop", {31'b0, obs_wr}, 32'd0);
        check("s1_hold", obs_data, 32'hFF00FF00);

        // Load and execute collide: load first.
        step(1, 5'd2, 32'h11111111, 1, 5'd3, 32'h22222222, 0, 0);
        check("s2_e_ready", {31'b0, obs_eready}, 32'd0);
        check("s2_addr", {27'b0, obs_addr}, 32'd2);
        check("s2_data", obs_data, 32'h11111111);
        step(0, 0, 0, 1, 5'd3, 32'h22222222, 0, 0);
        check("s2_e_addr", {27'b0, obs_addr}, 32'd3);
        check("s2_e_data", obs_data, 32'h22222222);

        // Execute blocked by pending load to x5.
        step(0, 0, 0, 0, 0, 0, 1, 5'd5);
        check("s3_pend", {31'b0, pending[5]}, 32'd1);
        step(0, 0, 0, 1, 5'd5, 32'h55555555, 0, 0);
        check("s3_blocked", {31'b0, obs_eready}, 32'd0);
        step(1, 5'd5, 32'hCAFEBABE, 1, 5'd5, 32'h55555555, 0, 0);
        check("s3_load_data", obs_data, 32'hCAFEBABE);
        check("s3_pend_clr", {31'b0, pending[5]}, 32'd0);
        step(0, 0, 0, 1, 5'd5, 32'h55555555, 0, 0);
        check("s3_e_go", {31'b0, obs_eready}, 32'd1);
        check("s3_e_data", obs_data, 32'h55555555);

        // Reserve and load-clear of x7 together.
        step(0, 0, 0, 0, 0, 0, 1, 5'd7);
        step(1, 5'd7, 32'h77777777, 0, 0, 0, 1, 5'd7);
        check("s4_pend", {31'b0, pending[7]}, 32'd1);
        check("s4_addr", {27'b0, obs_addr}, 32'd7);
        check("s4_wr", {31'b0, obs_wr}, 32'd1);
        step(1, 5'd7, 32'h77770000, 0, 0, 0, 0, 0);

        // x0 write and x0 reserve are no-ops.
        step(0, 0, 0, 1, 5'd0, 32'hDEADBEEF, 1, 5'd0);
        check("s5_wr", {31'b0, obs_wr}, 32'd0);
        check("s5_pend", pending, 32'd0);

        // Reset right after the acceptance of x4.
        step(0, 0, 0, 0, 0, 0, 1, 5'd9);
        step(0, 0, 0, 1, 5'd4, 32'h44444444, 0, 0);
        #1;
        async_rst_n = 0;
        #1;
        check("s6_wr", {31'b0, rd_write}, 32'd0);
        check("s6_addr", {27'b0, rd_addr}, 32'd0);
        check("s6_data", rd_data, 32'd0);
        check("s6_pend", pending, 32'd0);
        l_valid = 1; l_addr = 5'd6; l_data = 32'h66666666;
        reserve_valid = 1; reserve_addr = 5'd9;
        e_valid = 1; e_addr = 5'd9;
        #1;
        check("s6_rst_l_ready", {31'b0, l_ready}, 32'd1);
        check("s6_rst_e_ready", {31'b0, e_ready}, 32'd0);
        l_valid = 0;
        #1;
        check("s6_rst_e_ready2", {31'b0, e_ready}, 32'd0);
        reserve_valid = 0;
        #1;
        check("s6_rst_e_ready3", {31'b0, e_ready}, 32'd1);
        l_valid = 1; reserve_valid = 1;
        @(posedge clk);
        #1;
        check("s6_rst_noacc_wr", {31'b0, rd_write}, 32'd0);
        check("s6_rst_noacc_data", rd_data, 32'd0);
        check("s6_rst_noacc_pend", pending, 32'd0);
        idle_inputs();
        model_reset();
        @(negedge clk);
        async_rst_n = 1;
        @(posedge clk);
        #1;

        // Random traffic over a narrow address range to force collisions.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 9) < 2, 5'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/armleocpu_regfile_writeback.md
ARMLEOCPU_REGFILE_WRITEBACK -- requirements
Module: armleocpu_regfile_writeback

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports named clk and async_rst_n.
REQ-002 Port list (name, direction, width, meaning):
- clk, in, 1, clock, rising edge.
- async_rst_n, in, 1, asynchronous active-low reset.
- l_valid, in, 1, load-unit writeback request.
- l_ready, out, 1, load request accepted.
- l_addr, in, 5, load destination register.
- l_data, in, 32, load result.
- e_valid, in, 1, execute writeback request.
- e_ready, out, 1, execute request accepted.
- e_addr, in, 5, execute destination register.
- e_data, in, 32, execute result.
- reserve_valid, in, 1, decode reserves a register for a pending load.
- reserve_addr, in, 5, register to reserve.
- rd_write, out, 1, regfile write enable.
- rd_addr, out, 5, regfile write address.
- rd_data, out, 32, regfile write data.
- pending, out, 32, scoreboard; bit n=1 means a load to xn is outstanding.

Function
REQ-003 SHALL accept at most one request per cycle; a request is accepted when valid && ready are both high at a rising clk edge.
REQ-004 SHALL set l_ready equal to 1 at all times; loads never stall.
REQ-005 SHALL compute e_ready = !l_valid && !pending[e_addr] && !(reserve_valid && reserve_addr==e_addr && e_addr!=0).
REQ-006 On the edge after an accepted request, SHALL drive rd_write=1 with the accepted addr/data for exactly one cycle (registered, 1-cycle latency); otherwise rd_write=0.
REQ-007 Accepted requests with addr 0 SHALL be consumed with rd_write=0.
REQ-008 While rd_write=0, rd_addr and rd_data SHALL hold their last values.
REQ-009 An accepted load SHALL clear pending[l_addr] on the acceptance edge.
REQ-010 reserve_valid with reserve_addr!=0 SHALL set pending[reserve_addr] on that edge; reserve of x0 SHALL be ignored.
REQ-011 A simultaneous reserve and load-clear of the same register SHALL leave the bit set.
REQ-012 Reserving an already-pending register SHALL leave it set, with no error.
REQ-013 pending[0] SHALL always be 0.

Reset
REQ-014 Asserting async_rst_n low SHALL immediately force rd_write=0, rd_addr=0, rd_data=0 and pending=0, including mid-transfer; the in-flight write is dropped.
REQ-015 During reset, l_ready SHALL be 1 and e_ready SHALL follow REQ-005 with pending=0; nothing SHALL be accepted while reset is asserted.

Configuration
REQ-016 With ARMLEOCPU_WB_BYPASS_EN defined, rd_write/rd_addr/rd_data SHALL be driven combinationally from the request accepted in the current cycle (0-cycle latency), and scoreboard behaviour SHALL be unchanged.
REQ-017 Without ARMLEOCPU_WB_BYPASS_EN, the outputs SHALL be registered as in REQ-006.

Structure
REQ-018 A shared package armleocpu_defines SHALL hold the register-address width (5), the XLEN (32) constant, and a writeback-request struct {addr, data}.
REQ-019 The scoreboard SHALL be a sub-module armleocpu_wb_scoreboard with ports set_valid/set_addr, clr_valid/clr_addr and pending.

Verification
REQ-020 The bench SHALL cover, one scenario each:
- e write x1=FF00FF00, no load -> e_ready=1; next cycle rd_write=1, rd_addr=1, rd_data=FF00FF00; following cycle rd_write=0.
- l_valid and e_valid in the same cycle (l x2=11111111, e x3=22222222) -> load is written first and e_ready=0; x3 is written one cycle later.
- reserve x5, then e_valid to x5 -> e_ready=0 until load x5=CAFEBABE is accepted; pending[5] then clears and the e write proceeds the following cycle.
- reserve x7 together with load x7 -> pending[7] stays 1 and rd_write x7 is issued.
- e write x0=DEADBEEF and reserve x0 -> rd_write stays 0 and pending stays 0.
- reset asserted one cycle after acceptance of x4 -> rd_write=0 and pending=0 immediately; x4 is not written.
- The REQ-016 (combinational) and REQ-017 (registered) latency variants SHALL each be checked with the macro defined and with it undefined.
